// File: rtl/duty_ctrl.sv
// duty_ctrl -- two-channel duty register adjusted by push buttons.
//
// Raw sel/push_up/push_down are synchronized (two flops) and the buttons are
// debounced. A single debounced press steps the active channel by one, and
// holding the button auto-repeats every REPEAT_CYCLES cycles. Pressing both
// buttons locks out stepping until both are released. The active channel
// only follows sel while idle with no button pressed.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   sel        raw channel select (1 = channel 1, 0 = channel 2)
//   push_up    raw increment button
//   push_down  raw decrement button
//   duty1      channel-1 duty value, saturates at [0, DUTY_MAX]
//   duty2      channel-2 duty value, saturates at [0, DUTY_MAX]
//   active_ch  channel currently in use (1 = channel 1)
//   upd        one-cycle strobe in the first cycle a duty register changes

// Debouncer: q toggles once din has disagreed with it for N consecutive
// samples; a single agreeing sample restarts the count.
module duty_ctrl_db #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (din != q) begin
      if (cnt == CW'(N - 1)) begin
        q   <= ~q;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

module duty_ctrl #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] DUTY_MAX      = 8'd200,
  parameter logic [WIDTH-1:0] DUTY_INIT     = 8'd100,
  parameter int               DB_CYCLES     = 4,
  parameter int               REPEAT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             push_up,
  input  logic             push_down,
  output logic [WIDTH-1:0] duty1,
  output logic [WIDTH-1:0] duty2,
  output logic             active_ch,
  output logic             upd
);
  localparam int RW = $clog2(REPEAT_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  // {sel, up, down} through two flops
  logic [2:0] sync1, sync2;
  logic       sel_s, up_s, down_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sel, push_up, push_down};
      sync2 <= sync1;
    end
  end

  assign {sel_s, up_s, down_s} = sync2;

  logic up_db, down_db;

  duty_ctrl_db #(.N(DB_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .din(up_s), .q(up_db)
  );
  duty_ctrl_db #(.N(DB_CYCLES)) u_db_dn (
    .clk(clk), .reset(reset), .din(down_s), .q(down_db)
  );

  state_t        state;
  logic          held_up;   // direction latched on entry to HOLD
  logic [RW-1:0] rpt;

  logic             one_btn, both_btn, none_btn;
  logic             step_en, step_up, can_step;
  logic [WIDTH-1:0] cur, nxt;

  assign one_btn  = up_db ^ down_db;
  assign both_btn = up_db & down_db;
  assign none_btn = ~(up_db | down_db);

  always_comb begin
    step_en = 1'b0;
    step_up = up_db;
    case (state)
      IDLE:    step_en = one_btn;
      HOLD:    step_en = one_btn && (up_db == held_up) &&
                         (rpt == RW'(REPEAT_CYCLES - 1));
      default: step_en = 1'b0;
    endcase
  end

  // Saturating step on the active channel; a step at a limit is a no-op
  // and must not strobe upd.
  assign cur      = active_ch ? duty1 : duty2;
  assign can_step = step_up ? (cur < DUTY_MAX) : (cur != '0);
  assign nxt      = step_up ? cur + 1'b1 : cur - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      held_up   <= 1'b0;
      rpt       <= '0;
      duty1     <= DUTY_INIT;
      duty2     <= DUTY_INIT;
      active_ch <= 1'b1;
      upd       <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (step_en && can_step) begin
        if (active_ch) duty1 <= nxt;
        else           duty2 <= nxt;
        upd <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (both_btn) begin
            state <= LOCK;
          end else if (one_btn) begin
            state   <= HOLD;
            held_up <= up_db;
            rpt     <= '0;
          end else begin
            active_ch <= sel_s;
          end
        end
        HOLD: begin
          if (both_btn) begin
            state <= LOCK;
          end else if (none_btn) begin
            state <= IDLE;
          end else if (up_db != held_up) begin
            // direction swapped without a gap: re-arm from IDLE
            state <= IDLE;
          end else if (rpt == RW'(REPEAT_CYCLES - 1)) begin
            rpt <= '0;
          end else begin
            rpt <= rpt + 1'b1;
          end
        end
        LOCK: begin
          if (none_btn) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_duty_ctrl.sv
module tb_duty_ctrl;
  logic       clk = 1'b0;
  logic       reset, sel, push_up, push_down;
  logic [7:0] duty1, duty2;
  logic       active_ch, upd;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int base;

  duty_ctrl dut (
    .clk(clk), .reset(reset), .sel(sel), .push_up(push_up),
    .push_down(push_down), .duty1(duty1), .duty2(duty2),
    .active_ch(active_ch), .upd(upd)
  );

  always #5 clk = ~clk;

  // count upd pulses, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (upd === 1'b1) upd_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance n rising edges, return at the following falling edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b1; push_up = 1'b0; push_down = 1'b0;
    @(negedge clk);
    cyc(3);
    chk("rst_duty1", duty1, 100);
    chk("rst_duty2", duty2, 100);
    chk("rst_active", active_ch, 1);
    chk("rst_upd", upd, 0);
    reset = 1'b0;
    cyc(5);

    // single 10-cycle press on channel 1: step lands at edge 7
    base = upd_cnt;
    push_up = 1'b1;
    cyc(6);
    chk("p1_e6_duty1", duty1, 100);
    chk("p1_e6_upd", upd, 0);
    cyc(1);
    chk("p1_e7_duty1", duty1, 101);
    chk("p1_e7_upd", upd, 1);
    chk("p1_e7_duty2", duty2, 100);
    cyc(1);
    chk("p1_e8_upd", upd, 0);
    cyc(2);
    push_up = 1'b0;
    cyc(30);
    chk("p1_duty1", duty1, 101);
    chk("p1_upd_cnt", upd_cnt - base, 1);

    // channel 2 held down for 40 cycles: steps at edges 7, 23, 39
    sel = 1'b0;
    cyc(6);
    chk("p2_active", active_ch, 0);
    base = upd_cnt;
    push_down = 1'b1;
    cyc(7);
    chk("p2_e7", duty2, 99);
    cyc(16);
    chk("p2_e23", duty2, 98);
    cyc(16);
    chk("p2_e39", duty2, 97);
    cyc(1);
    push_down = 1'b0;
    cyc(30);
    chk("p2_duty2", duty2, 97);
    chk("p2_duty1", duty1, 101);
    chk("p2_upd_cnt", upd_cnt - base, 3);

    // bouncing button never settles long enough
    sel = 1'b1;
    cyc(6);
    base = upd_cnt;
    for (int i = 0; i < 10; i++) begin
      push_up = ~push_up;
      cyc(2);
    end
    push_up = 1'b0;
    cyc(20);
    chk("bounce_duty1", duty1, 101);
    chk("bounce_upd", upd_cnt - base, 0);

    // saturate channel 1 at 200
    base = upd_cnt;
    push_up = 1'b1;
    cyc(1700);
    chk("sat_hi_duty1", duty1, 200);
    chk("sat_hi_steps", upd_cnt - base, 99);
    base = upd_cnt;
    cyc(200);
    chk("sat_hi_hold", duty1, 200);
    chk("sat_hi_noupd", upd_cnt - base, 0);
    push_up = 1'b0;
    cyc(20);

    // saturate channel 2 at 0
    sel = 1'b0;
    cyc(6);
    base = upd_cnt;
    push_down = 1'b1;
    cyc(1600);
    chk("sat_lo_duty2", duty2, 0);
    chk("sat_lo_steps", upd_cnt - base, 97);
    base = upd_cnt;
    cyc(200);
    chk("sat_lo_hold", duty2, 0);
    chk("sat_lo_noupd", upd_cnt - base, 0);
    push_down = 1'b0;
    cyc(20);

    // both buttons: lock, partial release stays locked
    base = upd_cnt;
    push_up = 1'b1; push_down = 1'b1;
    cyc(40);
    chk("lock_both", upd_cnt - base, 0);
    push_down = 1'b0;
    cyc(40);
    chk("lock_one", upd_cnt - base, 0);
    chk("lock_duty2", duty2, 0);
    push_up = 1'b0;
    cyc(20);
    push_up = 1'b1;
    cyc(7);
    chk("unlock_duty2", duty2, 1);
    chk("unlock_upd", upd, 1);
    cyc(3);
    push_up = 1'b0;
    cyc(20);
    chk("unlock_cnt", upd_cnt - base, 1);

    // sel change while held is ignored until release
    push_up = 1'b1;
    cyc(8);
    sel = 1'b1;
    cyc(8);
    chk("selhold_active", active_ch, 0);
    push_up = 1'b0;
    cyc(12);
    chk("selrel_active", active_ch, 1);
    chk("selhold_duty2", duty2, 2);

    // reset in the middle of a hold
    sel = 1'b0;
    cyc(6);
    chk("pre_rst_active", active_ch, 0);
    push_up = 1'b1;
    cyc(10);
    chk("pre_rst_duty2", duty2, 3);
    reset = 1'b1;
    sel = 1'b1;
    cyc(2);
    chk("mid_rst_duty1", duty1, 100);
    chk("mid_rst_duty2", duty2, 100);
    chk("mid_rst_active", active_ch, 1);
    chk("mid_rst_upd", upd, 0);
    reset = 1'b0;
    cyc(6);
    chk("post_rst_e6", duty1, 100);
    chk("post_rst_e6_upd", upd, 0);
    cyc(1);
    chk("post_rst_e7", duty1, 101);
    chk("post_rst_e7_upd", upd, 1);
    push_up = 1'b0;
    cyc(20);
    chk("post_rst_duty2", duty2, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/duty_ctrl.md
DUTY_CTRL -- requirements
Module: duty_ctrl

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter WIDTH, default 8: duty register width.
REQ-002 The block SHALL have parameter DUTY_MAX, default 8'd200: upper saturation limit, inclusive.
REQ-003 The block SHALL have parameter DUTY_INIT, default 8'd100: reset value of both duty registers.
REQ-004 The block SHALL have parameter DB_CYCLES, default 4: debounce stability count in clk cycles, minimum 1.
REQ-005 The block SHALL have parameter REPEAT_CYCLES, default 16: auto-repeat period while a button is held, minimum 2.
Ports: name, direction, width, meaning.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port sel, input, 1: raw channel select; 1 selects channel 1, 0 selects channel 2.
REQ-009 The block SHALL have port push_up, input, 1: raw, asynchronous increment button.
REQ-010 The block SHALL have port push_down, input, 1: raw, asynchronous decrement button.
REQ-011 The block SHALL have port duty1, output, WIDTH: registered channel-1 duty value.
REQ-012 The block SHALL have port duty2, output, WIDTH: registered channel-2 duty value.
REQ-013 The block SHALL have port active_ch, output, 1: registered channel in use (1 = channel 1).
REQ-014 The block SHALL have port upd, output, 1: one-cycle strobe, high in the first cycle a duty register holds a new value.

Function
REQ-015 sel, push_up and push_down SHALL each pass through a two-flop synchronizer before any other use.
REQ-016 Each synchronized button SHALL have a debounced level (up_db, down_db) and a counter.
REQ-017 The debounced level SHALL toggle on the edge where the synchronized input has differed from it for DB_CYCLES consecutive samples; any agreeing sample SHALL clear the counter.
REQ-018 The FSM SHALL have states IDLE, HOLD and LOCK.
REQ-019 IDLE, exactly one of up_db or down_db high: the FSM SHALL apply one step to the active channel, clear the repeat counter and go to HOLD.
REQ-020 IDLE, both up_db and down_db high: the FSM SHALL go to LOCK without stepping.
REQ-021 IDLE, both up_db and down_db low: active_ch SHALL load the synchronized sel.
REQ-022 While the FSM is not in IDLE, or either button is high, active_ch SHALL hold its value.
REQ-023 HOLD, same single button still high: the repeat counter SHALL increment; on reaching REPEAT_CYCLES-1 the FSM SHALL apply one step and clear the counter.
REQ-024 HOLD, both buttons high: the FSM SHALL go to LOCK without stepping.
REQ-025 HOLD, both buttons low: the FSM SHALL return to IDLE.
REQ-026 LOCK: the FSM SHALL return to IDLE only when both up_db and down_db are low; no steps SHALL occur in LOCK.
REQ-027 Step size SHALL be 1; increments SHALL saturate at DUTY_MAX and decrements at 0.
REQ-028 A step at a limit SHALL leave the register unchanged and SHALL NOT pulse upd.
REQ-029 Only the register selected by active_ch SHALL change; the other SHALL hold.
REQ-030 Latency SHALL be fixed: a raw button level set up before rising edge N SHALL be visible on duty1/duty2 and upd after edge N+DB_CYCLES+2 (edge 7 counting N as edge 1, for DB_CYCLES=4).
REQ-031 upd SHALL be registered and high for exactly one cycle per changed value.

Reset
REQ-032 When reset is high at a rising edge, duty1 and duty2 SHALL go to DUTY_INIT.
REQ-033 When reset is high at a rising edge, active_ch SHALL go to 1 and upd to 0.
REQ-034 When reset is high at a rising edge, the FSM SHALL go to IDLE and all synchronizers, debounced levels and counters SHALL go to 0.
REQ-035 Reset SHALL take priority over every other event.
REQ-036 A button still held when reset deasserts SHALL be treated as a fresh press: debounce, then one step.

Verification
REQ-037 Bench SHALL cover: sel=1, push_up pulse of 10 cycles -> duty1 100->101 at edge 7, one upd pulse, duty2 stays 100.
REQ-038 Bench SHALL cover: sel=0, push_down held 40 cycles -> duty2 steps to 99, then 98 and 97 at 16-cycle intervals, each step with one upd.
REQ-039 Bench SHALL cover: push_up bouncing, toggling every 2 cycles for 20 cycles -> no step, upd stays 0.
REQ-040 Bench SHALL cover: duty1 at 200, push_up held -> duty1 stays 200, upd never pulses; duty at 0 with push_down held -> stays 0, upd never pulses.
REQ-041 Bench SHALL cover: both buttons high together -> no step, LOCK; release one -> still no step; release both, then press up -> normal step.
REQ-042 Bench SHALL cover: sel toggled while push_up held -> active_ch unchanged until release; reset asserted mid-hold, button kept high -> values back to 100 and 1, then one step at edge 7 after reset deasserts.
